// File: rtl/if_pkg.sv
// Shared types for the instruction fetch unit: FSM states, reset PC default
// and the fetch-queue entry layout.
package if_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DRAIN
   } fetch_state_e;

   localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Fetch queue: power-of-two circular buffer of {pc, inst} entries with a
// synchronous flush that empties it in one cycle.
module if_fifo
   import if_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  fetch_entry_t             push_entry,
   input  logic                     pop,
   output fetch_entry_t             head_entry,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + PTR_ONE;
         if (pop)  rptr_d = rptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wptr_q] <= push_entry;
   end

   assign head_entry = mem_q[rptr_q];
   assign empty      = (count_q == '0);
   assign count      = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: single-outstanding imem requester feeding a fetch queue.
// Optional macro IF_FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module if_fetch_unit
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IF_RESET_PC,
   parameter int          QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic [6:0]  id_opcode,
   output logic [2:0]  id_funct3,
   output logic [6:0]  id_funct7
);

   localparam int CW = $clog2(QDEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d, req_pc_q, req_pc_d, redirect_tgt;
   logic          drop_q, drop_d;
   logic          fifo_push, fifo_pop, fifo_empty, byp_hit;
   logic [CW-1:0] fifo_count;
   fetch_entry_t  fifo_head, rsp_entry, out_entry;
   int            occ_after;
   logic          unused_bits;

   assign redirect_tgt = {redirect_pc[31:2], 2'b00};
   assign unused_bits  = ^redirect_pc[1:0];
   assign rsp_entry    = '{pc: req_pc_q, inst: imem_rdata};

`ifdef IF_FETCH_BYPASS_EN
   assign byp_hit = (state_q == S_WAIT) && imem_rvalid && fifo_empty && !redirect;
`else
   assign byp_hit = 1'b0;
`endif

   assign fifo_pop  = !fifo_empty && id_ready;
   assign id_valid  = !fifo_empty || byp_hit;
   assign out_entry = byp_hit ? rsp_entry : (fifo_empty ? '0 : fifo_head);
   assign id_pc     = out_entry.pc;
   assign id_inst   = out_entry.inst;
   assign id_opcode = out_entry.inst[6:0];
   assign id_funct3 = out_entry.inst[14:12];
   assign id_funct7 = out_entry.inst[31:25];
   assign imem_req  = (state_q == S_REQ);
   assign imem_addr = req_pc_q;

   // pc_q is the next address to fetch; req_pc_q is the address on the bus or in flight.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      req_pc_d  = req_pc_q;
      drop_d    = drop_q;
      fifo_push = 1'b0;
      occ_after = int'(fifo_count) - (fifo_pop ? 1 : 0);
      case (state_q)
         S_IDLE: begin
            if (redirect) begin
               state_d  = S_REQ;
               req_pc_d = redirect_tgt;
            end else if (int'(fifo_count) < QDEPTH) begin
               state_d  = S_REQ;
               req_pc_d = pc_q;
            end
         end
         S_REQ: begin
            if (imem_gnt) begin
               if (redirect || drop_q) begin
                  state_d = S_DRAIN;
                  drop_d  = 1'b0;
               end else begin
                  state_d = S_WAIT;
                  pc_d    = req_pc_q + 32'd4;
               end
            end else if (redirect) begin
               drop_d = 1'b1;
            end
         end
         S_WAIT: begin
            // A redirect meeting the response retires it here, so no drain is needed.
            if (imem_rvalid) begin
               if (redirect) begin
                  state_d  = S_REQ;
                  req_pc_d = redirect_tgt;
               end else begin
                  fifo_push = !(byp_hit && id_ready);
                  occ_after = occ_after + (fifo_push ? 1 : 0);
                  if (occ_after < QDEPTH) begin
                     state_d  = S_REQ;
                     req_pc_d = pc_q;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end else if (redirect) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (imem_rvalid) begin
               state_d  = S_REQ;
               req_pc_d = redirect ? redirect_tgt : pc_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (redirect) pc_d = redirect_tgt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         drop_q   <= drop_d;
      end
   end

   if_fifo #(.DEPTH(QDEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect),
      .push       (fifo_push),
      .push_entry (rsp_entry),
      .pop        (fifo_pop),
      .head_entry (fifo_head),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit (default build, QDEPTH=4, RESET_PC=0).
module tb_if_fetch_unit;

   localparam logic [31:0] KEY = 32'hDEAD_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic [6:0]  id_opcode;
   logic [2:0]  id_funct3;
   logic [6:0]  id_funct7;

   int n_checks = 0;
   int n_fail   = 0;
   bit auto_rsp = 1'b0;

   if_fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_ready    (id_ready),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_inst     (id_inst),
      .id_opcode   (id_opcode),
      .id_funct3   (id_funct3),
      .id_funct7   (id_funct7)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock; the auto responder answers a granted request on the next cycle.
   task automatic tick();
      logic        hs;
      logic [31:0] a;
      hs = imem_req && imem_gnt;
      a  = imem_addr;
      @(posedge clk);
      #1;
      if (auto_rsp) begin
         imem_rvalid = hs;
         imem_rdata  = hs ? (a ^ KEY) : 32'h0;
      end
   endtask

   task automatic run_seq(input logic [31:0] a0, input logic [31:0] p0, input int n, input int budget);
      logic [31:0] ea, ep;
      int pops;
      ea = a0; ep = p0; pops = 0;
      for (int c = 0; c < budget && pops < n; c++) begin
         if (imem_req && imem_gnt) begin
            check("fetch_addr", imem_addr, ea);
            ea = ea + 32'd4;
         end
         if (id_valid && id_ready) begin
            check("id_pc", id_pc, ep);
            check("id_inst", id_inst, ep ^ KEY);
            ep = ep + 32'd4;
            pops++;
         end
         tick();
      end
      check("seq_pops", 32'(pops), 32'(n));
   endtask

   task automatic do_reset();
      auto_rsp    = 1'b0;
      rst_n       = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      redirect    = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
      do_reset();
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", 32'(id_valid), 32'd0);
      check("rst_pc", id_pc, 32'h0);
      check("rst_inst", id_inst, 32'h0);

      // Streaming fetch with decode always ready
      rst_n = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1; auto_rsp = 1'b1;
      tick();
      check("first_req", 32'(imem_req), 32'd1);
      run_seq(32'h0, 32'h0, 4, 20);

      // Back-pressure fills the queue
      do_reset();
      rst_n = 1'b1; imem_gnt = 1'b1; id_ready = 1'b0; auto_rsp = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      check("full_req", 32'(imem_req), 32'd0);
      check("full_valid", 32'(id_valid), 32'd1);
      tick();
      check("full_req2", 32'(imem_req), 32'd0);
      id_ready = 1'b1;
      run_seq(32'h10, 32'h0, 4, 12);

      // Redirect while waiting for a response
      do_reset();
      rst_n = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
      tick();
      tick();
      redirect = 1'b1; redirect_pc = 32'h103;
      tick();
      redirect = 1'b0;
      check("drain_req", 32'(imem_req), 32'd0);
      check("drain_valid", 32'(id_valid), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
      tick();
      imem_rvalid = 1'b0;
      check("stale_valid", 32'(id_valid), 32'd0);
      check("redir_addr", imem_addr, 32'h100);
      check("redir_req", 32'(imem_req), 32'd1);
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'hFE12_3AB3;
      tick();
      imem_rvalid = 1'b0; id_ready = 1'b0;
      check("redir_pc", id_pc, 32'h100);
      check("redir_inst", id_inst, 32'hFE12_3AB3);
      check("opcode", 32'(id_opcode), 32'h33);
      check("funct3", 32'(id_funct3), 32'h3);
      check("funct7", 32'(id_funct7), 32'h7F);

      // Redirect together with response and pop
      tick();
      id_ready = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0001;
      redirect = 1'b1; redirect_pc = 32'h200;
      check("pre_flush_valid", 32'(id_valid), 32'd1);
      tick();
      redirect = 1'b0; imem_rvalid = 1'b0;
      check("flush_valid", 32'(id_valid), 32'd0);
      check("flush_req", 32'(imem_req), 32'd1);
      check("flush_addr", imem_addr, 32'h200);

      // Redirect at grant to the top word, then wrap
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      check("gnt_redir_req", 32'(imem_req), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
      tick();
      imem_rvalid = 1'b0;
      check("wrap_valid", 32'(id_valid), 32'd0);
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      auto_rsp = 1'b1;
      run_seq(32'hFFFF_FFFC, 32'hFFFF_FFFC, 2, 12);

      // Reset while waiting; late response after release
      do_reset();
      rst_n = 1'b1; imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000;
      check("rel_req", 32'(imem_req), 32'd0);
      tick();
      imem_rvalid = 1'b0;
      check("rel_req2", 32'(imem_req), 32'd1);
      check("rel_addr", imem_addr, 32'h0);
      check("rel_valid", 32'(id_valid), 32'd0);
      imem_gnt = 1'b1; auto_rsp = 1'b1;
      run_seq(32'h0, 32'h0, 1, 10);

      // Redirect while request is not yet granted
      do_reset();
      rst_n = 1'b1; imem_gnt = 1'b0;
      tick();
      redirect = 1'b1; redirect_pc = 32'h300;
      tick();
      redirect = 1'b0;
      check("hold_req", 32'(imem_req), 32'd1);
      check("hold_addr", imem_addr, 32'h0);
      tick();
      check("hold_addr2", imem_addr, 32'h0);
      imem_gnt = 1'b1;
      tick();
      check("late_gnt_req", 32'(imem_req), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
      tick();
      imem_rvalid = 1'b0;
      check("late_valid", 32'(id_valid), 32'd0);
      check("late_addr", imem_addr, 32'h300);
      auto_rsp = 1'b1;
      run_seq(32'h300, 32'h300, 2, 12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
